// File: rtl/audio_frontend_pkg.sv
// audio_frontend_pkg: shared state encoding, audio constants and gain scaling helper
package audio_frontend_pkg;

  typedef enum logic [1:0] {MUTED, RAMP_UP, RUN, RAMP_DOWN} st_t;

  localparam logic [7:0] MIDSCALE  = 8'd128;
  localparam logic [4:0] GAIN_FULL = 5'd16;

  // Scale an offset-binary sample about midscale by g/16, flooring, clamped to 8 bits
  function automatic logic [7:0] scale(input logic [7:0] avg, input logic [4:0] g);
    logic signed [14:0] dif;
    logic signed [14:0] prod;
    logic signed [14:0] res;
    dif  = $signed({7'd0, avg}) - 15'sd128;
    prod = dif * $signed({10'd0, g});
    res  = (prod >>> 4) + 15'sd128;
    return (res < 15'sd0) ? 8'd0 : (res > 15'sd255) ? 8'd255 : res[7:0];
  endfunction

endpackage

// File: rtl/af_clkgen.sv
// af_clkgen: free-running ADC conversion clock and the capture strobe derived from it
module af_clkgen
  import audio_frontend_pkg::*;
#(
  parameter int HALF_DIV = 4,
  parameter int CAP_DLY  = 2
) (
  input  logic clk,
  input  logic rst,
  output logic adc_clk,
  output logic cap
);

  localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);
  localparam logic [7:0] CAP_AT   = 8'(CAP_DLY - 1);

  logic [7:0] div_cnt;

  // divider restarts on every adc_clk toggle, so in the high half it counts cycles since the rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 8'd1;
      if (div_cnt == DIV_LAST) adc_clk <= ~adc_clk;
    end
  end

  // strobe is high in the cycle whose closing edge lies CAP_DLY cycles after the rise
  assign cap = adc_clk && (div_cnt == CAP_AT);

endmodule

// File: rtl/audio_frontend.sv
// audio_frontend: ADC capture, block averaging, click-free gain ramp and overload detection
module audio_frontend
  import audio_frontend_pkg::*;
#(
  parameter int         HALF_DIV = 4,
  parameter int         CAP_DLY  = 2,
  parameter int         DEC_LOG2 = 4,
  parameter logic [7:0] OVL_LO   = 8'd4,
  parameter logic [7:0] OVL_HI   = 8'd251
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] adc_data,
  output logic       adc_clk,
  output logic [7:0] audio,
  output logic       audio_vld,
  output logic       ovl,
  input  logic       ovl_clr
);

  localparam int         ACC_W = 8 + DEC_LOG2;
  localparam logic [7:0] LAST  = 8'((1 << DEC_LOG2) - 1);

  logic             cap;
  logic             smp_vld;
  logic [7:0]       smp;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       cnt;
  logic             avg_vld;
  logic [7:0]       avg;
  st_t              st;
  st_t              st_n;
  logic [4:0]       g;
  logic [4:0]       g_n;

  af_clkgen #(.HALF_DIV(HALF_DIV), .CAP_DLY(CAP_DLY)) u_clkgen (
    .clk(clk),
    .rst(rst),
    .adc_clk(adc_clk),
    .cap(cap)
  );

  // capture register; overload is judged on the captured code and a new set wins over clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp     <= '0;
      smp_vld <= 1'b0;
      ovl     <= 1'b0;
    end else begin
      smp_vld <= cap;
      if (cap) smp <= adc_data;
      ovl <= (cap && (adc_data <= OVL_LO || adc_data >= OVL_HI)) || (ovl && !ovl_clr);
    end
  end

  assign acc_sum = acc + ACC_W'(smp);

  // block accumulator; the completing sample goes into the average and the next block starts empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      avg     <= MIDSCALE;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= smp_vld && (cnt == LAST);
      if (smp_vld) begin
        acc <= (cnt == LAST) ? '0 : acc_sum;
        cnt <= (cnt == LAST) ? '0 : cnt + 8'd1;
        if (cnt == LAST) avg <= acc_sum[ACC_W-1:DEC_LOG2];
      end
    end
  end

  // gain state register, advanced only when a new average arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= MUTED;
      g  <= '0;
    end else begin
      st <= st_n;
      g  <= g_n;
    end
  end

  // ramps step one gain unit per output sample and reverse in place when en flips
  always_comb begin
    st_n = st;
    g_n  = g;
    if (avg_vld)
      case (st)
        MUTED: if (en) begin
          st_n = RAMP_UP;
          g_n  = 5'd1;
        end
        RUN: if (!en) begin
          st_n = RAMP_DOWN;
          g_n  = GAIN_FULL - 5'd1;
        end
        default: begin
          g_n  = en ? g + 5'd1 : g - 5'd1;
          st_n = (g_n == GAIN_FULL) ? RUN : (g_n == 5'd0) ? MUTED : en ? RAMP_UP : RAMP_DOWN;
        end
      endcase
  end

  // output stage applies the gain that takes effect on this sample boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio     <= MIDSCALE;
      audio_vld <= 1'b0;
    end else begin
      audio_vld <= avg_vld;
      if (avg_vld) audio <= (st_n == MUTED) ? MIDSCALE : scale(avg, g_n);
    end
  end

endmodule

// File: tb/tb_audio_frontend.sv
// tb_audio_frontend: table vectors, randomized blocks against a gain-ramp model, reset and overload corners
module tb_audio_frontend;

  logic       clk = 1'b0;
  logic       rst, en, ovl_clr;
  logic [7:0] adc_data;
  logic       adc_clk, audio_vld, ovl;
  logic [7:0] audio;
  logic       adc_clk1, audio_vld1, ovl1;
  logic [7:0] audio1;

  int n_run = 0;
  int n_fail = 0;
  int q0[$];
  int q1[$];
  int mg = 0;
  bit mo = 1'b0;
  int exp_last = 0;

  typedef struct {
    bit e;
    int d;
    int exp_a;
    bit exp_o;
    bit clr;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  audio_frontend dut (
    .clk(clk), .rst(rst), .en(en), .adc_data(adc_data), .adc_clk(adc_clk),
    .audio(audio), .audio_vld(audio_vld), .ovl(ovl), .ovl_clr(ovl_clr)
  );

  audio_frontend #(.DEC_LOG2(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .adc_data(adc_data), .adc_clk(adc_clk1),
    .audio(audio1), .audio_vld(audio_vld1), .ovl(ovl1), .ovl_clr(ovl_clr)
  );

  always @(negedge clk) begin
    if (audio_vld) q0.push_back(int'(audio));
    if (audio_vld1) q1.push_back(int'(audio1));
  end

  task automatic check(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_out(input int avg, input int g);
    int p;
    if (g == 0) return 128;
    p = (avg - 128) * g;
    p = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    p = p + 128;
    return (p < 0) ? 0 : (p > 255) ? 255 : p;
  endfunction

  function automatic int step_g(input bit e, input int g);
    return e ? ((g < 16) ? g + 1 : 16) : ((g > 0) ? g - 1 : 0);
  endfunction

  task automatic wait_rise(output int n, output int n_hi);
    n = 0;
    while (adc_clk !== 1'b0) begin
      @(posedge clk); #1; n++;
      if (n > 64) begin
        $display("FAIL adc_clk_timeout: got no fall within %0d cycles, required one", n);
        $fatal(1);
      end
    end
    n_hi = n;
    while (adc_clk !== 1'b1) begin
      @(posedge clk); #1; n++;
      if (n > 64) begin
        $display("FAIL adc_clk_timeout: got no rise within %0d cycles, required one", n);
        $fatal(1);
      end
    end
  endtask

  task automatic capture(input int d, input bit clr);
    int n, nh;
    logic [7:0] junk;
    junk = (d >= 128) ? 8'd60 : 8'd190;
    wait_rise(n, nh);
    adc_data = junk;
    @(posedge clk); #1;
    adc_data = 8'(d);
    ovl_clr = clr;
    @(posedge clk); #1;
    adc_data = junk;
    ovl_clr = 1'b0;
    mo = (d <= 4 || d >= 251) ? 1'b1 : clr ? 1'b0 : mo;
  endtask

  task automatic block(input bit e, input int mode, input int d, input bit clr0);
    int sum, v;
    sum = 0;
    en = e;
    for (int i = 0; i < 16; i++) begin
      v = (mode == 0) ? d : (mode == 1) ? ((i % 2) ? 255 : 0) : int'($urandom_range(0, 255));
      sum += v;
      capture(v, clr0 && i == 0);
    end
    repeat (3) @(posedge clk);
    #1;
    mg = step_g(e, mg);
    exp_last = model_out(sum / 16, mg);
  endtask

  task automatic check_blk(input string nm);
    check({nm, "_vld_count"}, q0.size(), 1);
    if (q0.size() > 0) check({nm, "_audio"}, q0.pop_front(), exp_last);
    q0.delete();
    check({nm, "_ovl"}, int'(ovl), int'(mo));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    mg = 0;
    mo = 1'b0;
  endtask

  initial begin
    int n, nh, k, v;
    rst = 1'b1; en = 1'b0; ovl_clr = 1'b0; adc_data = 8'd128;
    tbl = '{
      '{1, 200, 132, 0, 0}, '{1, 200, 137, 0, 0}, '{1, 200, 141, 0, 0}, '{1, 200, 146, 0, 0},
      '{0, 50, 113, 0, 0},  '{0, 50, 118, 0, 0},  '{0, 50, 123, 0, 0},  '{0, 50, 128, 0, 0},
      '{0, 255, 128, 1, 0}, '{1, 0, 120, 1, 0},   '{1, 100, 124, 0, 1}
    };
    repeat (2) @(posedge clk);
    #1;
    check("rst_adc_clk", int'(adc_clk), 0);
    check("rst_audio", int'(audio), 128);
    check("rst_audio_vld", int'(audio_vld), 0);
    check("rst_ovl", int'(ovl), 0);
    do_reset();
    wait_rise(n, nh);
    wait_rise(n, nh);
    check("adc_clk_period", n, 8);
    check("adc_clk_high", nh, 4);
    do_reset();

    foreach (tbl[i]) begin
      block(tbl[i].e, 0, tbl[i].d, tbl[i].clr);
      check("tbl_vld_count", q0.size(), 1);
      if (q0.size() > 0) check($sformatf("tbl%0d_audio", i), q0.pop_front(), tbl[i].exp_a);
      q0.delete();
      check($sformatf("tbl%0d_ovl", i), int'(ovl), int'(tbl[i].exp_o));
    end

    for (int i = 0; i < 30; i++) begin
      block($urandom_range(0, 3) != 0, 2, 0, $urandom_range(0, 7) == 0);
      check_blk("rand");
    end

    k = 0;
    while (mg != 9 && k < 40) begin
      block(mg < 9, 0, 200, 0);
      check_blk("to_g9");
      k++;
    end
    check("reach_g9", mg, 9);
    for (int i = 0; i < 10; i++) begin
      block(0, 0, 200, 0);
      check_blk("down_from_g9");
    end

    k = 0;
    while (mg != 16 && k < 40) begin
      block(1, 0, 200, 0);
      check_blk("ramp_up");
      k++;
    end
    block(1, 0, 200, 0);
    check_blk("full_gain");
    check("full_gain_200", exp_last, 200);
    block(1, 1, 0, 0);
    check_blk("alt_0_255");
    check("alt_ovl_set", int'(ovl), 1);
    block(1, 1, 0, 1);
    check_blk("clr_with_overload");
    check("clr_with_overload_ovl", int'(ovl), 1);
    @(posedge clk); #1 ovl_clr = 1'b1;
    @(posedge clk); #1 ovl_clr = 1'b0;
    mo = 1'b0;
    check("ovl_clr_alone", int'(ovl), 0);

    for (int i = 0; i < 18; i++) begin
      block(0, 0, 50, 0);
      check_blk("mute_ramp");
    end
    check("mute_ramp_end_gain", mg, 0);

    en = 1'b1;
    for (int i = 0; i < 7; i++) capture(255, 0);
    rst = 1'b1;
    #1;
    check("midrst_adc_clk", int'(adc_clk), 0);
    check("midrst_audio", int'(audio), 128);
    check("midrst_audio_vld", int'(audio_vld), 0);
    check("midrst_ovl", int'(ovl), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    mg = 0;
    mo = 1'b0;
    for (int i = 0; i < 15; i++) capture(200, 0);
    repeat (3) @(posedge clk);
    #1;
    check("postrst_no_early_vld", q0.size(), 0);
    check("dec0_count_15", q1.size(), 15);
    capture(200, 0);
    repeat (3) @(posedge clk);
    #1;
    check("postrst_vld_count", q0.size(), 1);
    if (q0.size() > 0) check("postrst_audio", q0.pop_front(), model_out(200, 1));
    check("dec0_count_16", q1.size(), 16);
    for (int i = 0; i < 16; i++) begin
      v = (q1.size() > 0) ? q1.pop_front() : -1;
      check($sformatf("dec0_audio%0d", i), v, model_out(200, i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_frontend.md
AUDIO_FRONTEND -- requirements
Module: audio_frontend

Interface
REQ-001 Parameter HALF_DIV, default 4: adc_clk half-period in clk cycles (range 2..255).
REQ-002 Parameter CAP_DLY, default 2: clk cycles after adc_clk rising edge at which adc_data is captured (range 1..HALF_DIV).
REQ-003 Parameter DEC_LOG2, default 4: log2 of raw samples averaged per output sample (range 0..8).
REQ-004 Parameter OVL_LO, default 8'd4 / OVL_HI, default 8'd251: raw-code overload thresholds.
REQ-005 clk  input  1  system clock (200 MHz domain shared with the modulator).
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  level; 1 = unmute/run, 0 = mute.
REQ-008 adc_data  input  8  unsigned offset-binary ADC code, midscale 128.
REQ-009 adc_clk  output  1  conversion clock to the external ADC.
REQ-010 audio  output  8  unsigned audio sample for the modulator's adc_in, midscale 128.
REQ-011 audio_vld  output  1  one-cycle strobe when audio updates.
REQ-012 ovl  output  1  sticky overload flag.
REQ-013 ovl_clr  input  1  one-cycle clear of ovl.

Function
REQ-014 adc_clk SHALL be a free-running square wave, period 2*HALF_DIV clk cycles, driven from a register.
REQ-015 adc_data SHALL be registered exactly CAP_DLY cycles after each adc_clk 0->1 register transition; the first capture occurs only after the first rising edge following reset.
REQ-016 Each capture SHALL add into an accumulator of width 8+DEC_LOG2; after 2^DEC_LOG2 captures the average (accumulator >> DEC_LOG2, truncating) SHALL be latched and the accumulator restarted from the next capture with no sample dropped.
REQ-017 A gain register g (5 bits, 0..16) SHALL scale each average: audio = 128 + (((avg-128) * g) >>> 4), signed arithmetic in at least 14 bits, with arithmetic shift, result clamped to 0..255.
REQ-018 audio and audio_vld SHALL update 2 clk cycles after the capture that completes a decimation block (pipeline: average, scale).
REQ-019 State machine: MUTED (g=0), RAMP_UP, RUN (g=16), RAMP_DOWN; state and g update only on output-sample boundaries.
REQ-020 MUTED->RAMP_UP when en=1; RAMP_UP: g+=1 per output sample, ->RUN when g reaches 16; RUN->RAMP_DOWN when en=0; RAMP_DOWN: g-=1 per sample, ->MUTED at g=0.
REQ-021 en toggling mid-ramp SHALL reverse direction from the current g (RAMP_UP<->RAMP_DOWN) without jumping.
REQ-022 In MUTED, audio SHALL hold 128 and audio_vld SHALL still pulse at the output sample rate.
REQ-023 ovl SHALL set on any capture with adc_data <= OVL_LO or >= OVL_HI, regardless of state; ovl_clr clears it; simultaneous set and clear SHALL leave ovl=1.
REQ-024 DEC_LOG2=0 SHALL pass every capture through (one output per capture).

Reset
REQ-025 On rst: adc_clk=0, divider/delay/capture counters=0, accumulator=0, state=MUTED, g=0, audio=8'd128, audio_vld=0, ovl=0.
REQ-026 rst asserted mid-block SHALL discard the partial accumulation; after release, first audio_vld follows a full fresh block.

Structure
REQ-027 A shared package SHALL hold the state enum, MIDSCALE=8'd128, GAIN_FULL=5'd16.
REQ-028 One sub-module, af_clkgen, SHALL produce adc_clk and the capture strobe.

Verification
REQ-029 HALF_DIV=4, CAP_DLY=2: adc_clk period 8 cycles; capture strobe 2 cycles after each rise.
REQ-030 en=1 constant, adc_data=200, DEC_LOG2=4: audio climbs 128,132,137,...,200 over 16 output samples (g=1..16), then holds 200.
REQ-031 In RUN, en->0 with adc_data=50: audio ramps from 50 to 128 in 16 samples, then holds 128 with audio_vld continuing.
REQ-032 adc_data alternating 0/255 per capture, g=16: audio=127 (average truncation), ovl=1; ovl_clr pulse coincident with a further overload leaves ovl=1.
REQ-033 rst pulse after 7 of 16 captures: outputs return to reset values; next audio_vld exactly 16 captures after release.
REQ-034 en toggled 1->0 when g=9: g steps 8,7,...,0 with no discontinuity in audio.
